// File: rtl/regfile_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : regfile_write_arbiter_pkg
// Brief   : Shared register-file constants and helpers for the write arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_write_arbiter_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ZERO_REG = 0;

    // Pointer width for an arbiter over n requesters (n >= 2).
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : regfile_write_arbiter_if
// Brief   : Writeback request bus plus regfile write/read ports of the arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wb_stall;
    logic                      ctrl_writeEnable;
    logic [ADDR_W-1:0]         ctrl_writeReg;
    logic [DATA_W-1:0]         data_writeReg;
    logic [ADDR_W-1:0]         ctrl_readRegA;
    logic [ADDR_W-1:0]         ctrl_readRegB;
    logic [DATA_W-1:0]         rf_readRegA;
    logic [DATA_W-1:0]         rf_readRegB;
    logic [DATA_W-1:0]         data_readRegA;
    logic [DATA_W-1:0]         data_readRegB;

    modport master (
        output req_valid, req_reg, req_data, wb_stall,
        output ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
        input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  data_readRegA, data_readRegB
    );

    modport slave (
        input  req_valid, req_reg, req_data, wb_stall,
        input  ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
        output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output data_readRegA, data_readRegB
    );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
//------------------------------------------------------------------------------
// Module  : rr_priority_pick
// Brief   : Combinational rotating-priority picker: first valid at or after ptr.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     valid,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] grantIdx,
    output logic                  anyGrant
);

    always_comb begin
        int unsigned       sum;
        logic [IDX_W-1:0]  idx;
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        sum      = 0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            sum = 32'(ptr) + 32'(k);
            if (sum >= 32'(N)) begin
                sum = sum - 32'(N);
            end
            idx = IDX_W'(sum);
            if (!anyGrant && valid[idx]) begin
                grant[idx] = 1'b1;
                grantIdx   = idx;
                anyGrant   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : regfile_write_arbiter
// Brief   : Round-robin arbiter for the single regfile write port, one-cycle
//           registered write; optional write-to-read bypass via RF_ARB_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
) (
    input wire logic              clock,
    input wire logic              ctrl_reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int IDX_W = idxWidth(NUM_REQ);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [ADDR_W-1:0] C_ZERO_REG = ADDR_W'(RF_ZERO_REG);

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grantIdx;
    logic               w_anyGrant;
    logic               w_accept;
    logic [IDX_W-1:0]   w_ptrNext;
    logic [ADDR_W-1:0]  w_selReg;
    logic [DATA_W-1:0]  w_selData;

    logic [IDX_W-1:0]   r_ptr;
    logic               r_writeEnable;
    logic [ADDR_W-1:0]  r_writeReg;
    logic [DATA_W-1:0]  r_writeData;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid    (bus.req_valid),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grantIdx (w_grantIdx),
        .anyGrant (w_anyGrant)
    );

    // Reset also blocks accepts so an in-flight request must be re-held.
    assign w_accept      = w_anyGrant & ~bus.wb_stall & ~ctrl_reset;
    assign bus.req_ready = w_accept ? w_grant : '0;

    assign w_ptrNext = (w_grantIdx == C_LAST_IDX) ? '0 : w_grantIdx + 1'b1;
    assign w_selReg  = bus.req_reg[w_grantIdx*ADDR_W +: ADDR_W];
    assign w_selData = bus.req_data[w_grantIdx*DATA_W +: DATA_W];

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_ptr         <= '0;
            r_writeEnable <= 1'b0;
            r_writeReg    <= '0;
            r_writeData   <= '0;
        end else if (w_accept) begin
            r_ptr         <= w_ptrNext;
            // Writes to the zero register are consumed but never committed.
            r_writeEnable <= (w_selReg != C_ZERO_REG);
            r_writeReg    <= w_selReg;
            r_writeData   <= w_selData;
        end else begin
            r_writeEnable <= 1'b0;
        end
    end

    assign bus.ctrl_writeEnable = r_writeEnable;
    assign bus.ctrl_writeReg    = r_writeReg;
    assign bus.data_writeReg    = r_writeData;

`ifdef RF_ARB_BYPASS_EN
    logic w_hitA;
    logic w_hitB;

    // Forward the write committing this cycle to the datapath readers.
    assign w_hitA = r_writeEnable && (r_writeReg == bus.ctrl_readRegA) && (bus.ctrl_readRegA != C_ZERO_REG);
    assign w_hitB = r_writeEnable && (r_writeReg == bus.ctrl_readRegB) && (bus.ctrl_readRegB != C_ZERO_REG);

    assign bus.data_readRegA = w_hitA ? r_writeData : bus.rf_readRegA;
    assign bus.data_readRegB = w_hitB ? r_writeData : bus.rf_readRegB;
`else
    logic w_unusedReadIdx;

    assign w_unusedReadIdx   = ^{bus.ctrl_readRegA, bus.ctrl_readRegB};
    assign bus.data_readRegA = bus.rf_readRegA;
    assign bus.data_readRegB = bus.rf_readRegB;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_regfile_write_arbiter
// Brief   : Directed vector-table bench for regfile_write_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;

    logic clock;
    logic ctrl_reset;

    int checks;
    int errors;

    regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile model fed by the arbiter's write port.
    logic [31:0] rfModel [32];
    initial for (int i = 0; i < 32; i++) rfModel[i] = 32'h0;
    always @(posedge clock) begin
        if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0)
            rfModel[bus.ctrl_writeReg] <= bus.data_writeReg;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  valid;
        logic [14:0] regs;
        logic [95:0] datas;
        logic [2:0]  expReady;
        logic        expWe;
        logic        chkRegData;
        logic [4:0]  expReg;
        logic [31:0] expData;
    } vec_t;

    localparam logic [14:0] DEF_REGS = {5'd12, 5'd11, 5'd10};
    localparam logic [95:0] DEF_DATA = {32'hA2, 32'hA1, 32'hA0};

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] valid,
                                input logic [14:0] regs, input logic [95:0] datas,
                                input logic [2:0] expReady, input logic expWe,
                                input logic chk, input logic [4:0] expReg,
                                input logic [31:0] expData);
        vec_t v;
        v.rst = rst; v.stall = stall; v.valid = valid; v.regs = regs; v.datas = datas;
        v.expReady = expReady; v.expWe = expWe; v.chkRegData = chk;
        v.expReg = expReg; v.expData = expData;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [14:0] regs7;
        logic [95:0] data7;
        logic [14:0] regs0;
        logic [95:0] data0;
        logic [31:0] expBypassA;
        logic [31:0] expBypassB;

        checks = 0;
        errors = 0;
        regs7 = {5'd12, 5'd7, 5'd10};
        data7 = {32'hA2, 32'hDEAD_BEEF, 32'hA0};
        regs0 = {5'd0, 5'd11, 5'd10};
        data0 = {32'h5, 32'hA1, 32'hA0};

        //               rst  stall valid   regs      datas     ready   we   chk  reg    data
        vecs.push_back(mk(1, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b000, 0, 1, 5'd0,  32'h0));
        vecs.push_back(mk(0, 0, 3'b010, regs7,    data7,    3'b010, 1, 1, 5'd7,  32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0, 3'b000, DEF_REGS, DEF_DATA, 3'b000, 0, 1, 5'd7,  32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0, 3'b001, DEF_REGS, DEF_DATA, 3'b001, 1, 1, 5'd10, 32'hA0));
        vecs.push_back(mk(0, 0, 3'b000, DEF_REGS, DEF_DATA, 3'b000, 0, 1, 5'd10, 32'hA0));
        vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b010, 1, 1, 5'd11, 32'hA1));
        vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b100, 1, 1, 5'd12, 32'hA2));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b001, 1, 1, 5'd10, 32'hA0));
            vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b010, 1, 1, 5'd11, 32'hA1));
            vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b100, 1, 1, 5'd12, 32'hA2));
        end
        vecs.push_back(mk(0, 0, 3'b100, regs0,    data0,    3'b100, 0, 0, 5'd0,  32'h0));
        vecs.push_back(mk(0, 1, 3'b001, DEF_REGS, DEF_DATA, 3'b000, 0, 0, 5'd0,  32'h0));
        vecs.push_back(mk(0, 0, 3'b011, DEF_REGS, DEF_DATA, 3'b001, 1, 1, 5'd10, 32'hA0));
        vecs.push_back(mk(0, 1, 3'b111, DEF_REGS, DEF_DATA, 3'b000, 0, 0, 5'd0,  32'h0));
        vecs.push_back(mk(0, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b010, 1, 1, 5'd11, 32'hA1));
        vecs.push_back(mk(1, 0, 3'b111, DEF_REGS, DEF_DATA, 3'b000, 0, 1, 5'd0,  32'h0));
        vecs.push_back(mk(0, 0, 3'b110, DEF_REGS, DEF_DATA, 3'b010, 1, 1, 5'd11, 32'hA1));
        vecs.push_back(mk(0, 0, 3'b011, DEF_REGS, DEF_DATA, 3'b001, 1, 1, 5'd10, 32'hA0));

        ctrl_reset        = 1'b1;
        bus.req_valid     = '0;
        bus.req_reg       = DEF_REGS;
        bus.req_data      = DEF_DATA;
        bus.wb_stall      = 1'b0;
        bus.ctrl_readRegA = '0;
        bus.ctrl_readRegB = '0;
        bus.rf_readRegA   = '0;
        bus.rf_readRegB   = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            ctrl_reset    = v.rst;
            bus.wb_stall  = v.stall;
            bus.req_valid = v.valid;
            bus.req_reg   = v.regs;
            bus.req_data  = v.datas;
            #1;
            check($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(v.expReady));
            @(posedge clock);
            #1;
            check($sformatf("v%0d we", i), 32'(bus.ctrl_writeEnable), 32'(v.expWe));
            if (v.chkRegData) begin
                check($sformatf("v%0d reg", i), 32'(bus.ctrl_writeReg), 32'(v.expReg));
                check($sformatf("v%0d data", i), bus.data_writeReg, v.expData);
            end
        end

        check("rf r7 readback", rfModel[7], 32'hDEAD_BEEF);

        // Bypass: ptr is 1 here, only req0 (reg 4, data 9) is valid.
        @(negedge clock);
        ctrl_reset    = 1'b0;
        bus.wb_stall  = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_reg   = {5'd12, 5'd11, 5'd4};
        bus.req_data  = {32'hA2, 32'hA1, 32'h9};
        @(posedge clock);
        #1;
        bus.req_valid = 3'b000;
        check("byp we", 32'(bus.ctrl_writeEnable), 32'd1);
        check("byp reg", 32'(bus.ctrl_writeReg), 32'd4);
        bus.ctrl_readRegA = 5'd4;
        bus.rf_readRegA   = 32'h1;
        bus.ctrl_readRegB = 5'd4;
        bus.rf_readRegB   = 32'h2;
`ifdef RF_ARB_BYPASS_EN
        expBypassA = 32'h9;
        expBypassB = 32'h9;
`else
        expBypassA = 32'h1;
        expBypassB = 32'h2;
`endif
        #1;
        check("byp readA hit", bus.data_readRegA, expBypassA);
        check("byp readB hit", bus.data_readRegB, expBypassB);
        bus.ctrl_readRegA = 5'd0;
        #1;
        check("byp readA r0", bus.data_readRegA, 32'h1);
        bus.ctrl_readRegA = 5'd4;
        @(posedge clock);
        #1;
        check("byp readA idle", bus.data_readRegA, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
